muldiv_iter: RTL
================

// Module: muldiv_iter
// PURPOSE
//  Parametrised iterative multiply/divide unit for the EXE stage; generalises the
//  ALU HI/LO mult/div path to WIDTH bits, one radix-2 step per cycle, with a
//  start/valid handshake, a pipeline stall output and flush (cancel) support.
//  Result is packed {HI,LO} for the HI/LO register write in a later stage.
// PARAMETERS
//  WIDTH  32  operand width; product/{rem,quot} width is 2*WIDTH
//  CNT_W  $clog2(WIDTH+1)  iteration counter width (derived, not overridden)
// PORTS
//  clk     in   1        clock, all state on rising edge
//  rst     in   1        reset, asynchronous, active-high
//  start   in   1        request; accepted only in IDLE
//  op      in   2        0=MULT 1=MULTU 2=DIV 3=DIVU, sampled with start
//  cancel  in   1        flush: abort any operation in progress
//  a       in   WIDTH    multiplicand / dividend (rs), sampled with start
//  b       in   WIDTH    multiplier / divisor (rt), sampled with start
//  busy    out  1        registered; high in CALC and FIX
//  stall   out  1        comb: busy | (start & idle & ~cancel)
//  valid   out  1        registered; one-cycle pulse when hilo is updated
//  hilo    out  2*WIDTH  {HI,LO}; MUL: product; DIV: {remainder,quotient}
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, valid=0, hilo=0, counter=0, operand regs=0.
//  FSM IDLE -> CALC -> FIX -> IDLE.
//  IDLE: start & ~cancel at edge E0 -> latch op, |a|,|b| (signed ops) or a,b,
//        result sign flags; counter=0; go CALC. start in other states ignored.
//  CALC: one shift-add (MUL) or restoring subtract-shift (DIV) step per edge;
//        exactly WIDTH edges (E1..E_WIDTH), then FIX.
//  FIX: edge E_WIDTH+1 applies sign correction, writes hilo, valid=1 for one
//       cycle, busy=0, state=IDLE. Latency start-edge to valid = WIDTH+1 cycles.
//  hilo holds last result until next valid; never changes otherwise.
//  Sign rules: product negated if a^b sign (MULT); quotient negated if a^b sign,
//       remainder takes dividend sign (DIV). All arithmetic modulo 2^WIDTH.
//  DIV MIN/-1: quotient=MIN (wraps), remainder=0; no exception raised.
//  Divide by zero (DIV/DIVU): runs full latency; quotient=all-ones,
//       remainder=a (original, unsigned-unmodified dividend).
//  cancel: highest priority; any state -> IDLE on next edge, valid not
//       asserted, hilo unchanged. cancel with start in IDLE: start dropped.
//  start in the FIX cycle is ignored (busy=1); re-issue next cycle.
//  Async rst mid-operation: immediate return to reset values, no valid.
//  stall drops in the same cycle valid rises, so the waiting instruction
//       proceeds with hilo valid.
// STRUCTURE
//  muldiv_pkg: op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), state enum
//       (MD_IDLE, MD_CALC, MD_FIX) as localparams/typedefs shared with decode.
//  Sub-module muldiv_step: combinational one-iteration datapath (add/shift for
//       MUL, trial subtract/shift for DIV) on a 2*WIDTH+1 working register;
//       muldiv_iter owns FSM, counter, sign handling and output registers.
// TESTING  (WIDTH=32; cycle counts from start edge)
//  MULT a=FFFFFFFD b=00000007 -> valid at cycle 33, hilo=FFFFFFFF_FFFFFFEB.
//  MULTU a=b=FFFFFFFF -> hilo=FFFFFFFE_00000001; busy high cycles 1..32.
//  DIV a=FFFFFFF9 b=00000002 -> hilo=FFFFFFFF_FFFFFFFD; DIVU 100/7 -> 00000002_0000000E.
//  DIV 80000000/FFFFFFFF -> hilo=00000000_80000000; DIVU 64/0 -> 00000064_FFFFFFFF.
//  cancel at cycle 10 -> no valid, busy=0 at cycle 11, hilo unchanged; new start accepted.
//  start during busy ignored; rst at cycle 5 -> all outputs 0 immediately, no valid.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes used by decode
// and the FSM state type.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EXE stage and the multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);
  logic               start;
  logic [1:0]         op;
  logic               cancel;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               stall;
  logic               valid;
  logic [2*WIDTH-1:0] hilo;

  modport master (
    output start, op, cancel, a, b,
    input  busy, stall, valid, hilo
  );

  modport slave (
    input  start, op, cancel, a, b,
    output busy, stall, valid, hilo
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {upper(WIDTH+1), lower(WIDTH)} working register:
// right-shifting shift-add for multiply, left-shifting restoring divide otherwise.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [WIDTH-1:0]   opnd,
  input  logic [2*WIDTH:0]   work_in,
  output logic [2*WIDTH:0]   work_out
);

  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [2*WIDTH:0] shl;

  always_comb begin
    addend   = '0;
    sum      = '0;
    trial    = '0;
    shl      = '0;
    work_out = work_in;
    if (!is_div) begin
      // Multiplier sits in the low half; its LSB selects the add before shifting right.
      addend   = work_in[0] ? {1'b0, opnd} : '0;
      sum      = work_in[2*WIDTH:WIDTH] + addend;
      work_out = {1'b0, sum, work_in[WIDTH-1:1]};
    end else begin
      shl   = {work_in[2*WIDTH-1:0], 1'b0};
      trial = shl[2*WIDTH:WIDTH] - {1'b0, opnd};
      if (shl[2*WIDTH:WIDTH] >= {1'b0, opnd})
        work_out = {trial, shl[WIDTH-1:1], 1'b1};
      else
        work_out = {shl[2*WIDTH:WIDTH], shl[WIDTH-1:1], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative WIDTH-bit multiply/divide: magnitude datapath in muldiv_step, sign fix-up
// in a final cycle, result delivered as {HI,LO} with a one-cycle valid pulse.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  md
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int WW    = 2 * WIDTH + 1;

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q;
  logic               neg_lo_q;
  logic               neg_hi_q;
  logic               div_zero_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WW-1:0]      work_q;
  logic [WW-1:0]      work_step;
  logic               busy_q;
  logic               valid_q;
  logic [2*WIDTH-1:0] hilo_q;
  logic [2*WIDTH-1:0] result;

  logic               req_div;
  logic               req_sgn;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               accept;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                 input logic take_abs);
    logic [WIDTH-1:0] r;
    r = x;
    if (take_abs && x[WIDTH-1]) r = -r;
    return r;
  endfunction

  function automatic logic [2*WIDTH-1:0] signed_result(input logic [WW-1:0] work,
                                                       input logic is_div,
                                                       input logic neg_lo,
                                                       input logic neg_hi,
                                                       input logic div_zero);
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    prod = work[2*WIDTH-1:0];
    quot = work[WIDTH-1:0];
    rem  = work[2*WIDTH-1:WIDTH];
    if (!is_div) return neg_lo ? -prod : prod;
    if (neg_lo) quot = -quot;
    if (neg_hi) rem = -rem;
    // Divide by zero leaves |a| as remainder; the dividend-sign rule restores a exactly.
    if (div_zero) quot = '1;
    return {rem, quot};
  endfunction

  assign req_div = op_is_div(md.op);
  assign req_sgn = op_is_signed(md.op);
  assign a_neg   = req_sgn & md.a[WIDTH-1];
  assign b_neg   = req_sgn & md.b[WIDTH-1];
  assign a_mag   = magnitude(md.a, req_sgn);
  assign b_mag   = magnitude(md.b, req_sgn);
  assign accept  = (state_q == MD_IDLE) & md.start & ~md.cancel;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_q),
    .opnd     (opnd_q),
    .work_in  (work_q),
    .work_out (work_step)
  );

  assign result = signed_result(work_q, is_div_q, neg_lo_q, neg_hi_q, div_zero_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (accept) state_d = MD_CALC;
      MD_CALC: if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MD_FIX;
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (md.cancel) state_d = MD_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
      opnd_q     <= '0;
      work_q     <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      hilo_q     <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == MD_CALC) || (state_d == MD_FIX);
      valid_q <= (state_q == MD_FIX) && !md.cancel;
      // Issue boundary: capture magnitudes and sign flags for the whole operation.
      if (accept) begin
        cnt_q      <= '0;
        is_div_q   <= req_div;
        neg_lo_q   <= a_neg ^ b_neg;
        neg_hi_q   <= req_div & a_neg;
        div_zero_q <= req_div && (md.b == '0);
        opnd_q     <= req_div ? b_mag : a_mag;
        work_q     <= {{(WIDTH + 1){1'b0}}, (req_div ? a_mag : b_mag)};
      end else if ((state_q == MD_CALC) && !md.cancel) begin
        work_q <= work_step;
        cnt_q  <= cnt_q + 1'b1;
      end
      // Fix-up boundary: signed result lands in HI/LO together with valid.
      if ((state_q == MD_FIX) && !md.cancel)
        hilo_q <= result;
    end
  end

  assign md.busy  = busy_q;
  assign md.valid = valid_q;
  assign md.hilo  = hilo_q;
  assign md.stall = busy_q | accept;

endmodule
